// File: rtl/checkout_pkg.sv
// Shared types for the checkout sequencer: FSM state encoding and upc bit positions.
package checkout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam int UPC_U = 2;
  localparam int UPC_P = 1;
  localparam int UPC_C = 0;

endpackage

// File: rtl/checkout_sequencer_if.sv
// Scanner-side item channel and result channel of the checkout sequencer.
interface checkout_sequencer_if;

  // Item transfers when item_valid && item_ready on a rising edge; the scanner may change
  // upc/mark freely while item_ready is low. result_valid is a one-cycle pulse with no back-pressure.
  logic       item_valid;
  logic       item_ready;
  logic [2:0] upc;
  logic       mark;
  logic       result_valid;
  logic       discount;
  logic       stolen;

  modport master (
    output item_valid, upc, mark,
    input  item_ready, result_valid, discount, stolen
  );

  modport slave (
    input  item_valid, upc, mark,
    output item_ready, result_valid, discount, stolen
  );

endinterface

// File: rtl/item_classifier.sv
// Combinational classification of one scanned item from its U/P/C code bits and security mark.
module item_classifier (
  input  logic u,
  input  logic p,
  input  logic c,
  input  logic m,
  output logic discount,
  output logic stolen
);

  assign discount = p | (u & c);
  assign stolen   = (u & ~p & ~m) | (~u & ~c & ~m);

endmodule

// File: rtl/checkout_sequencer.sv
// Checkout sequencer: accepts scanned items, classifies them, keeps running totals, raises alarm on theft.
// Define CHECKOUT_SAT_CNT_EN to make the counters saturate instead of wrapping.
module checkout_sequencer
  import checkout_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  checkout_sequencer_if.slave  item,
  input  logic                 alarm_ack,
  input  logic                 clear,
  output logic                 alarm,
  output logic [CNT_W-1:0]     item_cnt,
  output logic [CNT_W-1:0]     disc_cnt,
  output logic [CNT_W-1:0]     stol_cnt,
  output state_t               state_dbg
);

  state_t     state_q, state_d;
  logic [2:0] upc_q;
  logic       mark_q;
  logic       cls_disc, cls_stol;
  logic       disc_hold_q, stol_hold_q;
  logic       accept, in_eval;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef CHECKOUT_SAT_CNT_EN
    bump = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
`else
    bump = v + 1'b1;
`endif
  endfunction

  item_classifier u_classifier (
    .u        (upc_q[UPC_U]),
    .p        (upc_q[UPC_P]),
    .c        (upc_q[UPC_C]),
    .m        (mark_q),
    .discount (cls_disc),
    .stolen   (cls_stol)
  );

  assign accept    = (state_q == IDLE) && item.item_valid;
  assign in_eval   = (state_q == EVAL);
  assign state_dbg = state_q;

  always_comb begin
    state_d           = state_q;
    item.item_ready   = 1'b0;
    item.result_valid = 1'b0;
    alarm             = 1'b0;
    case (state_q)
      IDLE: begin
        item.item_ready = 1'b1;
        if (item.item_valid) state_d = EVAL;
      end
      EVAL: begin
        item.result_valid = 1'b1;
        state_d = cls_stol ? ALARM : IDLE;
      end
      ALARM: begin
        alarm = 1'b1;
        if (alarm_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags show the live classification during the result pulse, then the held copy until the next one.
  assign item.discount = in_eval ? cls_disc : disc_hold_q;
  assign item.stolen   = in_eval ? cls_stol : stol_hold_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc_q       <= 3'b000;
      mark_q      <= 1'b0;
      disc_hold_q <= 1'b0;
      stol_hold_q <= 1'b0;
    end else begin
      if (accept) begin
        upc_q  <= item.upc;
        mark_q <= item.mark;
      end
      if (in_eval) begin
        disc_hold_q <= cls_disc;
        stol_hold_q <= cls_stol;
      end
    end
  end

  // clear outranks the EVAL increment so the totals read zero right after a clear edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      item_cnt <= '0;
      disc_cnt <= '0;
      stol_cnt <= '0;
    end else if (clear) begin
      item_cnt <= '0;
      disc_cnt <= '0;
      stol_cnt <= '0;
    end else if (in_eval) begin
      item_cnt <= bump(item_cnt);
      if (cls_disc) disc_cnt <= bump(disc_cnt);
      if (cls_stol) stol_cnt <= bump(stol_cnt);
    end
  end

endmodule
